// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Shares one register file (one write port, two registered read ports with
//   read-enable) between the CPU core (cpu) and the debug/bootloader unit (dbg).
//   Each requester holds req until a one-cycle ack; an operation is either a
//   read pair (rs1, rs2) or a single write (rd, data), never both.
//
// Ports
//   I_clk, I_reset_n             clock, async active-low reset
//   I_cpu_* / I_dbg_*            requester req, we, rs1, rs2, rd, data
//   O_cpu_* / O_dbg_*            ack pulse and held read results
//   O_rf_*                       register-file addresses, data and strobes
//   I_rf_regval1/2               register-file read data
//   O_busy                       high whenever an operation is in flight
//
// State table
//   state   | meaning
//   IDLE    | waiting for an eligible request; grants and latches operands
//   ISSUE   | one cycle with O_rf_we or O_rf_re asserted
//   CAPTURE | strobes low, read data sampled into holds, ack raised on exit

module regfile_arbiter #(
  parameter bit CPU_PRIORITY = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_cpu_req,
  input  logic        I_cpu_we,
  input  logic [4:0]  I_cpu_rs1,
  input  logic [4:0]  I_cpu_rs2,
  input  logic [4:0]  I_cpu_rd,
  input  logic [31:0] I_cpu_data,
  output logic        O_cpu_ack,
  output logic [31:0] O_cpu_regval1,
  output logic [31:0] O_cpu_regval2,
  input  logic        I_dbg_req,
  input  logic        I_dbg_we,
  input  logic [4:0]  I_dbg_rs1,
  input  logic [4:0]  I_dbg_rs2,
  input  logic [4:0]  I_dbg_rd,
  input  logic [31:0] I_dbg_data,
  output logic        O_dbg_ack,
  output logic [31:0] O_dbg_regval1,
  output logic [31:0] O_dbg_regval2,
  output logic [4:0]  O_rf_rs1,
  output logic [4:0]  O_rf_rs2,
  output logic [4:0]  O_rf_rd,
  output logic [31:0] O_rf_data,
  output logic        O_rf_re,
  output logic        O_rf_we,
  input  logic [31:0] I_rf_regval1,
  input  logic [31:0] I_rf_regval2,
  output logic        O_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state, state_nxt;
  logic   lat_we;
  logic   grant_dbg;
  logic   rr_last_dbg;
  logic   cpu_elig, dbg_elig, pick_dbg;

  // A requester in its ack cycle still has req high; masking it here keeps
  // it from being re-granted before it has seen the ack.
  assign cpu_elig = I_cpu_req & ~O_cpu_ack;
  assign dbg_elig = I_dbg_req & ~O_dbg_ack;

  always_comb begin
    pick_dbg = dbg_elig;
    if (cpu_elig && dbg_elig) begin
      pick_dbg = CPU_PRIORITY ? 1'b0 : ~rr_last_dbg;
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_elig || dbg_elig) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from state so an async reset drops them immediately.
  assign O_rf_we = (state == ISSUE) &  lat_we;
  assign O_rf_re = (state == ISSUE) & ~lat_we;
  assign O_busy  = (state != IDLE);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      lat_we        <= 1'b0;
      grant_dbg     <= 1'b0;
      rr_last_dbg   <= 1'b1;  // "dbg went last" so cpu wins the first tie
      O_rf_rs1      <= '0;
      O_rf_rs2      <= '0;
      O_rf_rd       <= '0;
      O_rf_data     <= '0;
      O_cpu_ack     <= 1'b0;
      O_dbg_ack     <= 1'b0;
      O_cpu_regval1 <= '0;
      O_cpu_regval2 <= '0;
      O_dbg_regval1 <= '0;
      O_dbg_regval2 <= '0;
    end else begin
      O_cpu_ack <= 1'b0;
      O_dbg_ack <= 1'b0;
      if (state == IDLE && (cpu_elig || dbg_elig)) begin
        grant_dbg <= pick_dbg;
        lat_we    <= pick_dbg ? I_dbg_we   : I_cpu_we;
        O_rf_rs1  <= pick_dbg ? I_dbg_rs1  : I_cpu_rs1;
        O_rf_rs2  <= pick_dbg ? I_dbg_rs2  : I_cpu_rs2;
        O_rf_rd   <= pick_dbg ? I_dbg_rd   : I_cpu_rd;
        O_rf_data <= pick_dbg ? I_dbg_data : I_cpu_data;
      end
      if (state == CAPTURE) begin
        rr_last_dbg <= grant_dbg;
        if (grant_dbg) begin
          O_dbg_ack <= 1'b1;
          if (!lat_we) begin
            O_dbg_regval1 <= I_rf_regval1;
            O_dbg_regval2 <= I_rf_regval2;
          end
        end else begin
          O_cpu_ack <= 1'b1;
          if (!lat_we) begin
            O_cpu_regval1 <= I_rf_regval1;
            O_cpu_regval2 <= I_rf_regval2;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

  typedef struct {
    bit          dbg;
    bit          we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    bit          isdbg;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  logic clk;
  logic rst_n;
  logic mem_clr;

  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [4:0]  cpu_rs1, cpu_rs2, cpu_rd, dbg_rs1, dbg_rs2, dbg_rd;
  logic [31:0] cpu_data, dbg_data;

  logic [1:0]       cpu_ack, dbg_ack, rf_re, rf_we, busy;
  logic [1:0][31:0] cpu_v1, cpu_v2, dbg_v1, dbg_v2, rf_data;
  logic [1:0][4:0]  rf_rs1, rf_rs2, rf_rd;

  logic [1:0][31:0] prev_c1, prev_c2, prev_d1, prev_d2;
  logic             rst_prev;

  int checks = 0;
  int failures = 0;

  exp_t sbq0[$];
  exp_t sbq1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 is cpu-priority; each has its own
  // register-file model (x0 reads zero, writes to x0 dropped, registered read).
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic [31:0] mem [32];
    logic [31:0] rv1, rv2;

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 32; i++) mem[i] <= '0;
        rv1 <= '0;
        rv2 <= '0;
      end else begin
        if (rf_we[g] && rf_rd[g] != 5'd0) mem[rf_rd[g]] <= rf_data[g];
        if (rf_re[g]) begin
          rv1 <= (rf_rs1[g] == 5'd0) ? 32'h0 : mem[rf_rs1[g]];
          rv2 <= (rf_rs2[g] == 5'd0) ? 32'h0 : mem[rf_rs2[g]];
        end
      end
    end

    regfile_arbiter #(.CPU_PRIORITY(g == 0 ? 1'b0 : 1'b1)) u_dut (
      .I_clk(clk), .I_reset_n(rst_n),
      .I_cpu_req(cpu_req), .I_cpu_we(cpu_we), .I_cpu_rs1(cpu_rs1),
      .I_cpu_rs2(cpu_rs2), .I_cpu_rd(cpu_rd), .I_cpu_data(cpu_data),
      .O_cpu_ack(cpu_ack[g]), .O_cpu_regval1(cpu_v1[g]), .O_cpu_regval2(cpu_v2[g]),
      .I_dbg_req(dbg_req), .I_dbg_we(dbg_we), .I_dbg_rs1(dbg_rs1),
      .I_dbg_rs2(dbg_rs2), .I_dbg_rd(dbg_rd), .I_dbg_data(dbg_data),
      .O_dbg_ack(dbg_ack[g]), .O_dbg_regval1(dbg_v1[g]), .O_dbg_regval2(dbg_v2[g]),
      .O_rf_rs1(rf_rs1[g]), .O_rf_rs2(rf_rs2[g]), .O_rf_rd(rf_rd[g]),
      .O_rf_data(rf_data[g]), .O_rf_re(rf_re[g]), .O_rf_we(rf_we[g]),
      .I_rf_regval1(rv1), .I_rf_regval2(rv2), .O_busy(busy[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h", nm, k, act, exp);
    end
  endtask

  task automatic sb_pop(input int k, input bit isdbg, input logic [31:0] a1, input logic [31:0] a2);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (k == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); have = 1'b1; end
    else if (k == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); have = 1'b1; end
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ack dut%0d requester=%0d actual=ack required=none", k, isdbg);
    end else begin
      chk("ack_requester", k, {31'd0, isdbg}, {31'd0, e.isdbg});
      chk("ack_regval1", k, a1, e.v1);
      chk("ack_regval2", k, a2, e.v2);
    end
  endtask

  // Scoreboard consumer plus hold-stability check for every non-ack cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cpu_ack[k]) sb_pop(k, 1'b0, cpu_v1[k], cpu_v2[k]);
      if (dbg_ack[k]) sb_pop(k, 1'b1, dbg_v1[k], dbg_v2[k]);
      if (rst_n && rst_prev) begin
        if (!cpu_ack[k]) begin
          chk("cpu_hold1_stable", k, cpu_v1[k], prev_c1[k]);
          chk("cpu_hold2_stable", k, cpu_v2[k], prev_c2[k]);
        end
        if (!dbg_ack[k]) begin
          chk("dbg_hold1_stable", k, dbg_v1[k], prev_d1[k]);
          chk("dbg_hold2_stable", k, dbg_v2[k], prev_d2[k]);
        end
      end
      prev_c1[k] <= cpu_v1[k];
      prev_c2[k] <= cpu_v2[k];
      prev_d1[k] <= dbg_v1[k];
      prev_d2[k] <= dbg_v2[k];
    end
    rst_prev <= rst_n;
  end

  task automatic push_both(input bit isdbg, input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    e.isdbg = isdbg; e.v1 = v1; e.v2 = v2;
    sbq0.push_back(e);
    sbq1.push_back(e);
  endtask

  task automatic push_one(input int k, input bit isdbg, input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    e.isdbg = isdbg; e.v1 = v1; e.v2 = v2;
    if (k == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  // Single-requester operation on both instances; checks 3-edge latency and
  // scrambles the requester's operands right after the grant edge.
  task automatic do_op(input vec_t v);
    int  n;
    bit  got;
    push_both(v.dbg, v.e1, v.e2);
    @(posedge clk); #1;
    if (v.dbg) begin
      dbg_we = v.we; dbg_rs1 = v.rs1; dbg_rs2 = v.rs2; dbg_rd = v.rd; dbg_data = v.data; dbg_req = 1'b1;
    end else begin
      cpu_we = v.we; cpu_rs1 = v.rs1; cpu_rs2 = v.rs2; cpu_rd = v.rd; cpu_data = v.data; cpu_req = 1'b1;
    end
    n = 0; got = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        chk("busy_after_grant", 0, {31'd0, busy[0]}, 32'd1);
        if (v.dbg) begin
          dbg_we = 1'($urandom_range(1, 0)); dbg_rs1 = 5'($urandom_range(31, 0));
          dbg_rs2 = 5'($urandom_range(31, 0)); dbg_rd = 5'($urandom_range(31, 0));
          dbg_data = $urandom;
        end else begin
          cpu_we = 1'($urandom_range(1, 0)); cpu_rs1 = 5'($urandom_range(31, 0));
          cpu_rs2 = 5'($urandom_range(31, 0)); cpu_rd = 5'($urandom_range(31, 0));
          cpu_data = $urandom;
        end
      end
      if (v.dbg ? dbg_ack[0] : cpu_ack[0]) begin
        got = 1'b1;
        n = i;
        chk("ack_in_step", 1, {31'd0, (v.dbg ? dbg_ack[1] : cpu_ack[1])}, 32'd1);
      end
    end
    chk("ack_latency_edges", 0, n, 32'd3);
    if (v.dbg) dbg_req = 1'b0;
    else       cpu_req = 1'b0;
  endtask

  vec_t tbl [8];

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce, de, nack;
    cpu_req = 0; cpu_we = 0; cpu_rs1 = 0; cpu_rs2 = 0; cpu_rd = 0; cpu_data = 0;
    dbg_req = 0; dbg_we = 0; dbg_rs1 = 0; dbg_rs2 = 0; dbg_rd = 0; dbg_data = 0;
    rst_n = 1'b0;
    mem_clr = 1'b1;

    //          dbg   we    rs1    rs2    rd     data            e1              e2
    tbl[0] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd1,  32'h0000BEEF, 32'h0,          32'h0};
    tbl[1] = '{1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h0,        32'h0000BEEF,   32'h0};
    tbl[2] = '{1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0000FEFE, 32'h0,          32'h0};
    tbl[3] = '{1'b1, 1'b0, 5'd0,  5'd1,  5'd0,  32'h0,        32'h0,          32'h0000BEEF};
    tbl[4] = '{1'b1, 1'b1, 5'd0,  5'd0,  5'd1,  32'h00001234, 32'h0,          32'h0000BEEF};
    tbl[5] = '{1'b0, 1'b0, 5'd1,  5'd1,  5'd0,  32'h0,        32'h00001234,   32'h00001234};
    tbl[6] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd31, 32'hFFFFFFFF, 32'h00001234,   32'h00001234};
    tbl[7] = '{1'b1, 1'b0, 5'd31, 5'd1,  5'd0,  32'h0,        32'hFFFFFFFF,   32'h00001234};

    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", k, {31'd0, busy[k]}, 32'd0);
      chk("reset_strobes", k, {30'd0, rf_re[k], rf_we[k]}, 32'd0);
      chk("reset_acks", k, {30'd0, cpu_ack[k], dbg_ack[k]}, 32'd0);
      chk("reset_rf_addr", k, {17'd0, rf_rs1[k], rf_rs2[k], rf_rd[k]}, 32'd0);
      chk("reset_rf_data", k, rf_data[k], 32'd0);
      chk("reset_cpu_hold", k, cpu_v1[k] | cpu_v2[k], 32'd0);
      chk("reset_dbg_hold", k, dbg_v1[k] | dbg_v2[k], 32'd0);
    end

    for (int t = 0; t < 8; t++) do_op(tbl[t]);

    // Reset while a write is in ISSUE: strobe and busy drop at once, no ack.
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_rd = 5'd3; cpu_data = 32'h77; cpu_req = 1'b1;
    @(posedge clk); #1;
    chk("issue_we_before_reset", 0, {31'd0, rf_we[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midop_reset_we", k, {31'd0, rf_we[k]}, 32'd0);
      chk("midop_reset_busy", k, {31'd0, busy[k]}, 32'd0);
    end
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("post_reset_cpu_hold1", k, cpu_v1[k], 32'd0);
      chk("post_reset_cpu_hold2", k, cpu_v2[k], 32'd0);
      chk("post_reset_dbg_hold1", k, dbg_v1[k], 32'd0);
      chk("post_reset_dbg_hold2", k, dbg_v2[k], 32'd0);
    end

    // Simultaneous reads after reset: cpu first on both instances, then dbg.
    push_both(1'b0, 32'h00001234, 32'hFFFFFFFF);
    push_both(1'b1, 32'hFFFFFFFF, 32'h0);
    @(posedge clk); #1;
    cpu_we = 0; cpu_rs1 = 5'd1;  cpu_rs2 = 5'd31; cpu_req = 1'b1;
    dbg_we = 0; dbg_rs1 = 5'd31; dbg_rs2 = 5'd0;  dbg_req = 1'b1;
    ce = 0; de = 0;
    for (int i = 1; i <= 20 && (ce == 0 || de == 0); i++) begin
      @(posedge clk); #1;
      if (cpu_ack[0] && ce == 0) begin ce = i; cpu_req = 1'b0; end
      if (dbg_ack[0] && de == 0) begin de = i; dbg_req = 1'b0; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("both_cpu_ack_edge", 0, ce, 32'd3);
    chk("both_dbg_ack_edge", 0, de, 32'd6);

    // cpu alone goes last, then both hold req continuously for four operations:
    // round-robin starts with dbg, cpu-priority starts with cpu, and both
    // alternate because the acked requester is masked in its ack cycle.
    do_op('{1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h00000055, 32'h00001234, 32'hFFFFFFFF});
    repeat (2) @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      push_one(0, 1'b1, 32'h00001234, 32'h00000055);
      push_one(0, 1'b0, 32'h00000055, 32'h00001234);
      push_one(1, 1'b0, 32'h00000055, 32'h00001234);
      push_one(1, 1'b1, 32'h00001234, 32'h00000055);
    end
    #1;
    cpu_we = 0; cpu_rs1 = 5'd5; cpu_rs2 = 5'd1; cpu_req = 1'b1;
    dbg_we = 0; dbg_rs1 = 5'd1; dbg_rs2 = 5'd5; dbg_req = 1'b1;
    nack = 0;
    for (int i = 1; i <= 40 && nack < 4; i++) begin
      @(posedge clk); #1;
      if (cpu_ack[0] || dbg_ack[0]) nack++;
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("contended_ack_count", 0, nack, 32'd4);

    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_drained", 0, sbq0.size(), 32'd0);
    chk("scoreboard_drained", 1, sbq1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
